// File: rtl/input_capture_if.sv
// Player-input bundle between the round controller / answer compare stage and input_capture.
// cap_valid qualifies captured. There is no ready, and captured is held stable while cap_valid is high outside CAPTURED.
interface input_capture_if;
  logic [3:0] sw;
  logic       tick;
  logic       round_start;
  logic       round_end;
  logic [3:0] stable_sw;
  logic [3:0] captured;
  logic       cap_valid;
  logic       timeout;
  logic [7:0] react_time;

  modport master (
    output sw, tick, round_start, round_end,
    input  stable_sw, captured, cap_valid, timeout, react_time
  );

  modport slave (
    input  sw, tick, round_start, round_end,
    output stable_sw, captured, cap_valid, timeout, react_time
  );
endinterface

// File: rtl/input_capture.sv
// Switch synchronizer/debouncer plus per-round answer capture with reaction timing.
// Optional macro CAPTURE_LOCK_EN: freeze captured at the first answer (default: last answer wins).
module input_capture #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input_capture_if.slave      bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    CAPTURED = 2'd2
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] stable_q, stable_d;
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  state_t     state_q, state_d;
  logic [3:0] base_q, base_d;
  logic [3:0] cap_q, cap_d;
  logic       valid_q, valid_d;
  logic       tmo_q, tmo_d;
  logic [7:0] react_q, react_d;

  assign sync1_d = bus.sw;
  assign sync2_d = sync1_q;

  // Each bit counts consecutive disagreeing cycles; it flips on the DEB_CYCLES-th one.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = 8'd0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cap_d   = cap_q;
    valid_d = valid_q;
    tmo_d   = tmo_q;
    react_d = react_q;
    if (bus.round_start) begin
      state_d = ARMED;
      base_d  = stable_q;
      valid_d = 1'b0;
      tmo_d   = 1'b0;
      react_d = 8'd0;
    end else begin
      case (state_q)
        ARMED: begin
          if (bus.tick && react_q != 8'hFF) begin
            react_d = react_q + 8'd1;
          end
          // A close and a change in the same cycle are scored as a timeout.
          if (bus.round_end) begin
            cap_d   = stable_q;
            valid_d = 1'b1;
            tmo_d   = 1'b1;
            state_d = IDLE;
          end else if (stable_q != base_q) begin
            cap_d   = stable_q;
            valid_d = 1'b1;
            state_d = CAPTURED;
          end
        end
        CAPTURED: begin
`ifdef CAPTURE_LOCK_EN
          cap_d = cap_q;
`else
          cap_d = stable_q;
`endif
          if (bus.round_end) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 4'd0;
      sync2_q  <= 4'd0;
      stable_q <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 8'd0;
      end
      state_q  <= IDLE;
      base_q   <= 4'd0;
      cap_q    <= 4'd0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      react_q  <= 8'd0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q  <= state_d;
      base_q   <= base_d;
      cap_q    <= cap_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
      react_q  <= react_d;
    end
  end

  assign bus.stable_sw  = stable_q;
  assign bus.captured   = cap_q;
  assign bus.cap_valid  = valid_q;
  assign bus.timeout    = tmo_q;
  assign bus.react_time = react_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_input_capture.sv
// Directed bench for input_capture: debounce, capture, timeout, lock, priority, saturation, reset.
module tb_input_capture;
  localparam int DEB = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         total;
  int         bad;

  input_capture_if ifc ();

  input_capture #(.DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc.slave),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic [3:0] v);
    ifc.sw = v;
    step(DEB + 4);
  endtask

  task automatic pulse_start();
    ifc.round_start = 1'b1;
    step(1);
    ifc.round_start = 1'b0;
  endtask

  task automatic pulse_end();
    ifc.round_end = 1'b1;
    step(1);
    ifc.round_end = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      ifc.tick = 1'b1;
      step(1);
      ifc.tick = 1'b0;
      step(1);
    end
  endtask

  initial begin
    logic [3:0] lock_exp;
    total = 0;
    bad   = 0;
    ifc.sw          = 4'd0;
    ifc.tick        = 1'b0;
    ifc.round_start = 1'b0;
    ifc.round_end   = 1'b0;
    rst_n           = 1'b0;
    step(3);
    check("rst_stable", 32'(ifc.stable_sw), 32'h0);
    check("rst_cap", 32'(ifc.captured), 32'h0);
    check("rst_valid", 32'(ifc.cap_valid), 32'h0);
    check("rst_react", 32'(ifc.react_time), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Glitch one cycle short of the debounce window.
    ifc.sw = 4'b0001;
    step(DEB - 1);
    ifc.sw = 4'b0000;
    step(20);
    check("deb_short", 32'(ifc.stable_sw), 32'h0);

    // Held: 2 sync edges plus DEB counting edges.
    ifc.sw = 4'b0001;
    step(DEB + 1);
    check("deb_before", 32'(ifc.stable_sw), 32'h0);
    step(1);
    check("deb_edge", 32'(ifc.stable_sw), 32'h1);
    set_sw(4'b0000);
    check("deb_release", 32'(ifc.stable_sw), 32'h0);

    // Capture with 5 ticks.
    pulse_start();
    check("cap_armed", 32'(dbg_state), 32'h1);
    check("cap_valid0", 32'(ifc.cap_valid), 32'h0);
    ticks(5);
    set_sw(4'b0101);
    check("cap_value", 32'(ifc.captured), 32'h5);
    check("cap_valid", 32'(ifc.cap_valid), 32'h1);
    check("cap_tmo", 32'(ifc.timeout), 32'h0);
    check("cap_react", 32'(ifc.react_time), 32'h5);
    check("cap_state", 32'(dbg_state), 32'h2);
    pulse_end();
    check("cap_end_state", 32'(dbg_state), 32'h0);
    check("cap_end_value", 32'(ifc.captured), 32'h5);

    // IDLE holds captured while switches move.
    set_sw(4'b0011);
    check("idle_hold", 32'(ifc.captured), 32'h5);

    // Timeout.
    pulse_start();
    check("tmo_react0", 32'(ifc.react_time), 32'h0);
    step(5);
    pulse_end();
    check("tmo_value", 32'(ifc.captured), 32'h3);
    check("tmo_valid", 32'(ifc.cap_valid), 32'h1);
    check("tmo_flag", 32'(ifc.timeout), 32'h1);
    check("tmo_state", 32'(dbg_state), 32'h0);
    pulse_end();
    check("idle_end_tmo", 32'(ifc.timeout), 32'h1);
    check("idle_end_state", 32'(dbg_state), 32'h0);

    // Lock behaviour.
    pulse_start();
    set_sw(4'b1000);
    check("lock_first", 32'(ifc.captured), 32'h8);
    check("lock_state", 32'(dbg_state), 32'h2);
    set_sw(4'b1100);
`ifdef CAPTURE_LOCK_EN
    lock_exp = 4'b1000;
`else
    lock_exp = 4'b1100;
`endif
    check("lock_second", 32'(ifc.captured), 32'(lock_exp));
    check("lock_react", 32'(ifc.react_time), 32'h0);
    pulse_end();
    check("lock_end_state", 32'(dbg_state), 32'h0);

    // Simultaneous start and end.
    ifc.round_start = 1'b1;
    ifc.round_end   = 1'b1;
    step(1);
    ifc.round_start = 1'b0;
    ifc.round_end   = 1'b0;
    check("sim_state", 32'(dbg_state), 32'h1);
    check("sim_valid", 32'(ifc.cap_valid), 32'h0);
    check("sim_react", 32'(ifc.react_time), 32'h0);

    // Saturation.
    ifc.tick = 1'b1;
    step(300);
    ifc.tick = 1'b0;
    check("sat_react", 32'(ifc.react_time), 32'hFF);
    check("sat_state", 32'(dbg_state), 32'h1);

    // Reset mid-round.
    rst_n = 1'b0;
    #2;
    check("mid_rst_stable", 32'(ifc.stable_sw), 32'h0);
    check("mid_rst_cap", 32'(ifc.captured), 32'h0);
    check("mid_rst_valid", 32'(ifc.cap_valid), 32'h0);
    check("mid_rst_tmo", 32'(ifc.timeout), 32'h0);
    check("mid_rst_react", 32'(ifc.react_time), 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(30);
    check("post_rst_stable", 32'(ifc.stable_sw), 32'hC);
    check("post_rst_valid", 32'(ifc.cap_valid), 32'h0);
    check("post_rst_state", 32'(dbg_state), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
